mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single external memory port between three requesters: i_cache line read, d_cache line read, and d_cache write-back.
- Sits between the core's cache miss interfaces and the memory controller.
- Sequences one burst at a time: arbitrate, issue command, then stream BURST_LEN data beats to or from the owning requester.

Parameters:
ADDR_W, 26, byte address width
DATA_W, 32, beat data width
BURST_LEN, 4, beats per transaction; power of 2, >=1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ic_rd_req  in  1  i_cache read request (level)
ic_rd_addr  in  ADDR_W  i_cache line address
ic_rd_gnt  out  1  1-cycle grant pulse
ic_rd_valid  out  1  read beat valid
ic_rd_last  out  1  final read beat
dc_rd_req  in  1  d_cache read request
dc_rd_addr  in  ADDR_W  d_cache read address
dc_rd_gnt  out  1  grant pulse
dc_rd_valid  out  1  read beat valid
dc_rd_last  out  1  final read beat
rd_data  out  DATA_W  read beat data, shared by both readers
dc_wr_req  in  1  d_cache write-back request
dc_wr_addr  in  ADDR_W  write-back address
dc_wr_data  in  DATA_W  current write beat
dc_wr_gnt  out  1  grant pulse
dc_wr_ready  out  1  current write beat accepted
dc_wr_done  out  1  1-cycle pulse, burst complete
mem_cmd_valid  out  1  command valid
mem_cmd_we  out  1  1 = write burst
mem_cmd_addr  out  ADDR_W  burst address
mem_cmd_ready  in  1  command accepted
mem_rvalid  in  1  read beat from memory
mem_rdata  in  DATA_W  read beat data
mem_wvalid  out  1  write beat valid
mem_wdata  out  DATA_W  write beat data
mem_wready  in  1  write beat accepted

Behaviour:
- Reset state: state=IDLE, owner=none, beat counter=0; every output 0.
  - Reset in any state abandons the burst immediately.
  - No last/done/valid is emitted for an abandoned burst.
- States: IDLE, CMD, RD_DATA, WR_DATA.
- IDLE:
  - Sample the req lines.
  - If any is high, latch the winner's addr and we, set owner, go to CMD.
  - The winner's gnt is a registered pulse, high for exactly the first cycle of CMD.
  - If no req is high, stay in IDLE.
- Fixed priority: dc_wr > dc_rd > ic_rd.
- A req dropped before it is sampled in IDLE receives no grant.
- After its grant, a requester may drop or keep req; it is not re-arbitrated until IDLE.
- CMD:
  - mem_cmd_valid=1; mem_cmd_addr and mem_cmd_we come from the latched values, stable until accepted.
  - On mem_cmd_ready: counter=0; go to RD_DATA (we=0) or WR_DATA (we=1).
  - mem_rvalid and mem_wready are ignored in CMD.
- RD_DATA:
  - Each mem_rvalid cycle, the owner's *_rd_valid is driven combinationally from mem_rvalid; rd_data=mem_rdata; counter increments.
  - *_rd_last=1 on the beat where counter==BURST_LEN-1; next state IDLE.
  - The non-owner's valid and last stay 0.
  - Gaps between beats are allowed.
- WR_DATA:
  - mem_wvalid=1, mem_wdata=dc_wr_data, dc_wr_ready=mem_wready.
  - Counter increments on each mem_wready.
  - On the accepted beat with counter==BURST_LEN-1: dc_wr_done pulses in the next cycle (registered); state returns to IDLE.
  - The d_cache advances dc_wr_data after each dc_wr_ready.
- Counter width is max(1, clog2(BURST_LEN)) and wraps to 0 at burst end. With BURST_LEN=1, every burst is a single beat and last accompanies it.
- Throughput: at minimum, one IDLE cycle between bursts.
  - Best case, a read takes 1 (IDLE) + 1 (CMD) + BURST_LEN cycles.
  - A req held continuously is re-granted as soon as IDLE is re-entered.
- Under fixed priority, ic_rd can starve while d_cache traffic persists. This is accepted; the in-order core stalls anyway.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A pointer holds the last-granted requester; search order is ic_rd -> dc_rd -> dc_wr -> ic_rd, starting after the pointer.
  - The pointer resets to dc_wr, so ic_rd has first priority after reset.
  - The pointer updates only on grant.
- Undefined: fixed priority as above.
- All other timing is identical in both builds.

Test Plan:
- ic_rd_req=1, addr=0x0000100, mem_cmd_ready on the 1st CMD cycle, 4 rvalid beats 0xA0..0xA3 → ic_rd_gnt pulse one cycle after req; mem_cmd_we=0, mem_cmd_addr=0x0000100; ic_rd_valid x4 with rd_data A0..A3; ic_rd_last on A3; dc_rd_valid stays 0.
- dc_wr_req=1, addr=0x0000200, mem_wready toggling 1,0,1,1,1 → mem_cmd_we=1; exactly 4 dc_wr_ready pulses; dc_wr_done one cycle after the 4th accept; return to IDLE.
- All three reqs high in the same IDLE cycle (fixed-priority build) → order of grants dc_wr, dc_rd, ic_rd, each after the previous burst completes. With MEM_ARB_RR_EN → ic_rd, dc_rd, dc_wr.
- mem_cmd_ready held 0 for 5 cycles → mem_cmd_valid and addr stable for all 5 cycles; mem_rvalid pulsed during CMD is ignored (no *_rd_valid).
- rst=1 after the 2nd read beat of a dc_rd burst → next cycle all outputs 0, state IDLE, no dc_rd_last. A fresh ic_rd_req then completes a full 4-beat burst.
- BURST_LEN=1 build: dc_rd_req, one rvalid 0x55 → dc_rd_valid and dc_rd_last in the same cycle; back to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-way burst arbiter for the external memory port (round-robin with MEM_ARB_RR_EN)
module mem_arbiter #(
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_rd_req,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic              ic_rd_gnt,
    output logic              ic_rd_valid,
    output logic              ic_rd_last,
    input  logic              dc_rd_req,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    output logic              dc_rd_gnt,
    output logic              dc_rd_valid,
    output logic              dc_rd_last,
    output logic [DATA_W-1:0] rd_data,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              dc_wr_gnt,
    output logic              dc_wr_ready,
    output logic              dc_wr_done,
    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    input  logic              mem_cmd_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wvalid,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wready
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, CMD, RD_DATA, WR_DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC_RD, OWN_DC_RD, OWN_DC_WR} owner_t;

    state_t            state, state_next;
    owner_t            owner;
    owner_t            win;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        gnt_q;
    logic              done_q;
    logic [ADDR_W-1:0] win_addr;
    logic              at_last;
    logic              rd_beat;

`ifdef MEM_ARB_RR_EN
    owner_t ptr;

    // Search starts just after the last-granted requester.
    always_comb begin
        win = OWN_NONE;
        case (ptr)
            OWN_IC_RD: begin
                if (dc_rd_req)      win = OWN_DC_RD;
                else if (dc_wr_req) win = OWN_DC_WR;
                else if (ic_rd_req) win = OWN_IC_RD;
            end
            OWN_DC_RD: begin
                if (dc_wr_req)      win = OWN_DC_WR;
                else if (ic_rd_req) win = OWN_IC_RD;
                else if (dc_rd_req) win = OWN_DC_RD;
            end
            default: begin
                if (ic_rd_req)      win = OWN_IC_RD;
                else if (dc_rd_req) win = OWN_DC_RD;
                else if (dc_wr_req) win = OWN_DC_WR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= OWN_DC_WR;
        else if (state == IDLE && win != OWN_NONE)
            ptr <= win;
    end
`else
    always_comb begin
        win = OWN_NONE;
        if (dc_wr_req)      win = OWN_DC_WR;
        else if (dc_rd_req) win = OWN_DC_RD;
        else if (ic_rd_req) win = OWN_IC_RD;
    end
`endif

    always_comb begin
        win_addr = ic_rd_addr;
        if (win == OWN_DC_WR)      win_addr = dc_wr_addr;
        else if (win == OWN_DC_RD) win_addr = dc_rd_addr;
    end

    assign at_last = (cnt == LAST_CNT);
    assign rd_beat = (state == RD_DATA) && mem_rvalid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win != OWN_NONE) state_next = CMD;
            CMD:     if (mem_cmd_ready) state_next = we_q ? WR_DATA : RD_DATA;
            RD_DATA: if (mem_rvalid && at_last) state_next = IDLE;
            WR_DATA: if (mem_wready && at_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= OWN_NONE;
            cnt    <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            gnt_q  <= 3'b000;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            gnt_q  <= 3'b000;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win != OWN_NONE) begin
                        owner  <= win;
                        addr_q <= win_addr;
                        we_q   <= (win == OWN_DC_WR);
                        gnt_q  <= {win == OWN_DC_WR, win == OWN_DC_RD, win == OWN_IC_RD};
                    end
                end
                CMD: if (mem_cmd_ready) cnt <= '0;
                RD_DATA: begin
                    if (mem_rvalid) begin
                        cnt <= at_last ? '0 : cnt + 1'b1;
                        if (at_last) owner <= OWN_NONE;
                    end
                end
                WR_DATA: begin
                    if (mem_wready) begin
                        cnt <= at_last ? '0 : cnt + 1'b1;
                        if (at_last) begin
                            owner  <= OWN_NONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ic_rd_gnt     = gnt_q[0];
    assign dc_rd_gnt     = gnt_q[1];
    assign dc_wr_gnt     = gnt_q[2];
    assign dc_wr_done    = done_q;

    assign mem_cmd_valid = (state == CMD);
    assign mem_cmd_we    = (state == CMD) && we_q;
    assign mem_cmd_addr  = (state == CMD) ? addr_q : '0;

    // Read beats pass straight through to whichever reader owns the burst.
    assign ic_rd_valid   = rd_beat && (owner == OWN_IC_RD);
    assign dc_rd_valid   = rd_beat && (owner == OWN_DC_RD);
    assign ic_rd_last    = ic_rd_valid && at_last;
    assign dc_rd_last    = dc_rd_valid && at_last;
    assign rd_data       = (state == RD_DATA) ? mem_rdata : '0;

    assign mem_wvalid    = (state == WR_DATA);
    assign mem_wdata     = (state == WR_DATA) ? dc_wr_data : '0;
    assign dc_wr_ready   = (state == WR_DATA) && mem_wready;

endmodule
